adc_word_serializer: RTL and testbench

Fabric-side serializer that produces the ADC-style serial lane consumed by the 8-bit DDR deserializer path. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per enabled clock. Alongside the data it emits a frame marker and a word-start strobe. It drives loopback and bench stimulus for lane bring-up: bitslip training, pattern checks and throughput tests. It supports a training pattern, idle fill on starvation, and a saturating underrun counter.

---
 rtl/adc_serdes_pkg.sv | 21 ++
 rtl/adc_word_serializer.sv | 125 ++++++++++++
 tb/tb_adc_word_serializer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serdes_pkg.sv
// Shared constants and types for the ADC-style serial lane (serializer and deserializer sides).
package adc_serdes_pkg;

  localparam int ADC_WORD_W = 8;

  typedef logic [ADC_WORD_W-1:0] adc_word_t;

  localparam adc_word_t ADC_IDLE_PATTERN  = 8'h00;
  localparam adc_word_t ADC_TRAIN_PATTERN = 8'hF0;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

  // Source chosen for the shift register at a word boundary.
  typedef enum logic [1:0] {
    LOAD_NONE,
    LOAD_TRAIN,
    LOAD_HOLD,
    LOAD_IDLE
  } load_sel_e;

endpackage

// File: rtl/adc_word_serializer.sv
// Parallel-to-serial lane driver: valid/ready word intake into a one-deep holding
// register, MSB-first shifting gated by CE, frame/word-start decode, training
// pattern override and idle fill with a saturating underrun counter.
module adc_word_serializer
  import adc_serdes_pkg::*;
#(
  parameter int               WIDTH         = ADC_WORD_W,
  parameter logic [WIDTH-1:0] IDLE_PATTERN  = WIDTH'(ADC_IDLE_PATTERN),
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(ADC_TRAIN_PATTERN)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             train,
  output logic             serial_o,
  output logic             frame_o,
  output logic             word_start_o,
  output logic             underrun_o,
  output logic [15:0]      underrun_cnt
);

  localparam int            PW       = $clog2(WIDTH);
  localparam logic [PW-1:0] POS_LAST = PW'(WIDTH - 1);
  localparam logic [PW-1:0] POS_HALF = PW'(WIDTH / 2);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [PW-1:0]    pos;
  logic             hold_full;
  logic             primed;

  logic             boundary;
  logic             accept;
  logic             flag_underrun;
  logic [WIDTH-1:0] load_word;
  load_sel_e        load_sel;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == UNDERRUN_MAX) ? value : value + 16'd1;
  endfunction

  // Word-boundary decision: which word enters the shift register and whether it is an underrun.
  always_comb begin
    load_sel      = LOAD_NONE;
    load_word     = IDLE_PATTERN;
    flag_underrun = 1'b0;
    boundary      = CE && (pos == POS_LAST);
    // An accept only happens into an empty holding register, so it never races the consume.
    accept        = tx_valid && !hold_full;
    if (boundary) begin
      if (train) begin
        load_sel  = LOAD_TRAIN;
        load_word = TRAIN_PATTERN;
      end else if (hold_full) begin
        load_sel  = LOAD_HOLD;
        load_word = hold;
      end else begin
        load_sel      = LOAD_IDLE;
        load_word     = IDLE_PATTERN;
        // Priming by an accept in this same cycle does not count; primed is the old value.
        flag_underrun = primed;
      end
    end
  end

  // Shift register and bit position; reset parks pos at the last bit so the first CE cycle loads.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg <= '0;
      pos   <= POS_LAST;
    end else if (CE) begin
      if (pos == POS_LAST) begin
        shreg <= load_word;
        pos   <= '0;
      end else begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        pos   <= pos + PW'(1);
      end
    end
  end

  // Holding-register occupancy and priming; runs every cycle regardless of CE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_full <= 1'b0;
      primed    <= 1'b0;
    end else begin
      if (accept) begin
        hold_full <= 1'b1;
        primed    <= 1'b1;
      end else if (load_sel == LOAD_HOLD) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Holding-register data; its contents are only meaningful while hold_full is set.
  always_ff @(posedge CLK) begin
    if (accept) begin
      hold <= tx_data;
    end
  end

  // Underrun pulse lines up with word_start_o of the idle word; counter saturates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      underrun_o   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      underrun_o <= flag_underrun;
      if (flag_underrun) begin
        underrun_cnt <= sat_inc(underrun_cnt);
      end
    end
  end

  assign tx_ready     = ~hold_full;
  assign serial_o     = shreg[WIDTH-1];
  assign frame_o      = (pos < POS_HALF);
  assign word_start_o = (pos == '0);

endmodule

// File: tb/tb_adc_word_serializer.sv
// Directed self-checking bench for adc_word_serializer (WIDTH=8 defaults).
module tb_adc_word_serializer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        train;
  logic        serial_o;
  logic        frame_o;
  logic        word_start_o;
  logic        underrun_o;
  logic [15:0] underrun_cnt;

  int          total = 0;
  int          bad   = 0;

  logic [7:0]  caps [0:31];
  int          ncap;
  int          nb;
  logic [7:0]  cur;

  adc_word_serializer dut (
    .CLK          (CLK),
    .RST          (RST),
    .CE           (CE),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .train        (train),
    .serial_o     (serial_o),
    .frame_o      (frame_o),
    .word_start_o (word_start_o),
    .underrun_o   (underrun_o),
    .underrun_cnt (underrun_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Advance one cycle and assemble serial words framed by word_start_o.
  task automatic step();
    tick();
    if (word_start_o) begin
      cur = {7'b0, serial_o};
      nb  = 1;
    end else begin
      cur = {cur[6:0], serial_o};
      nb  = nb + 1;
    end
    if (nb == 8 && ncap < 32) begin
      caps[ncap] = cur;
      ncap = ncap + 1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; CE = 1'b1; tx_valid = 1'b0; train = 1'b0; tx_data = 8'h00;
    tick();
    tick();
    RST = 1'b0;
    ncap = 0; nb = 0; cur = 8'h00;
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 1'b1; tx_valid = 1'b1; train = 1'b0; tx_data = 8'hFF;
    tick();
    tick();
    total++; if (serial_o !== 1'b0) begin bad++; $display("FAIL reset.serial got=%b want=0", serial_o); end
    total++; if (frame_o !== 1'b0) begin bad++; $display("FAIL reset.frame got=%b want=0", frame_o); end
    total++; if (word_start_o !== 1'b0) begin bad++; $display("FAIL reset.word_start got=%b want=0", word_start_o); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset.tx_ready got=%b want=1", tx_ready); end
    total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL reset.underrun got=%b want=0", underrun_o); end
    total++; if (underrun_cnt !== 16'h0000) begin bad++; $display("FAIL reset.cnt got=%h want=0000", underrun_cnt); end
    tx_valid = 1'b0;
  endtask

  task automatic test_first_word();
    logic [7:0] w;
    logic       exp_bit;
    w = 8'hA5;
    do_reset();
    tx_valid = 1'b1; tx_data = 8'hA5;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 1) begin
        tx_valid = 1'b0;
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL first.ready_c1 got=%b want=0", tx_ready); end
      end
      if (c == 9) begin
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL first.ready_c9 got=%b want=1", tx_ready); end
      end
      exp_bit = (c <= 8) ? 1'b0 : w[16 - c];
      total++; if (serial_o !== exp_bit) begin bad++; $display("FAIL first.serial c=%0d got=%b want=%b", c, serial_o, exp_bit); end
      total++; if (word_start_o !== (c == 1 || c == 9)) begin bad++; $display("FAIL first.word_start c=%0d got=%b want=%b", c, word_start_o, (c == 1 || c == 9)); end
      total++; if (frame_o !== (((c - 1) % 8) < 4)) begin bad++; $display("FAIL first.frame c=%0d got=%b want=%b", c, frame_o, (((c - 1) % 8) < 4)); end
      total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL first.underrun c=%0d got=%b want=0", c, underrun_o); end
    end
  endtask

  task automatic test_back_to_back();
    int   idx;
    int   pulses;
    logic fire;
    logic prev_ready;
    do_reset();
    idx = 0; pulses = 0;
    tx_valid = 1'b1; tx_data = 8'h01;
    for (int c = 1; c <= 136; c++) begin
      fire       = tx_valid && tx_ready;
      prev_ready = tx_ready;
      step();
      if (fire) begin
        idx = idx + 1;
        if (idx < 16) tx_data = 8'(idx + 1);
        else tx_valid = 1'b0;
      end
      if (underrun_o) pulses++;
      total++; if (word_start_o !== (((c - 1) % 8) == 0)) begin bad++; $display("FAIL b2b.word_start c=%0d got=%b", c, word_start_o); end
      if (c >= 9 && word_start_o) begin
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL b2b.ready_after_load c=%0d got=%b want=1", c, tx_ready); end
        total++; if (prev_ready !== 1'b0) begin bad++; $display("FAIL b2b.ready_at_boundary c=%0d got=%b want=0", c, prev_ready); end
      end
    end
    total++; if (ncap !== 17) begin bad++; $display("FAIL b2b.nwords got=%0d want=17", ncap); end
    for (int k = 0; k < 17; k++) begin
      total++; if (caps[k] !== 8'(k)) begin bad++; $display("FAIL b2b.word k=%0d got=%h want=%h", k, caps[k], 8'(k)); end
    end
    total++; if (idx !== 16) begin bad++; $display("FAIL b2b.accepts got=%0d want=16", idx); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL b2b.underrun_pulses got=%0d want=0", pulses); end
    total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL b2b.cnt got=%h want=0000", underrun_cnt); end
  endtask

  task automatic test_starvation();
    int         pulses;
    logic [7:0] expw [0:5];
    expw[0] = 8'h00; expw[1] = 8'h5A; expw[2] = 8'h00;
    expw[3] = 8'h00; expw[4] = 8'h00; expw[5] = 8'h77;
    do_reset();
    pulses = 0;
    tx_valid = 1'b1; tx_data = 8'h5A;
    for (int c = 1; c <= 48; c++) begin
      step();
      if (c == 1) tx_valid = 1'b0;
      if (c == 33) begin tx_valid = 1'b1; tx_data = 8'h77; end
      if (c == 34) tx_valid = 1'b0;
      if (underrun_o) begin
        pulses++;
        total++; if (!(c == 17 || c == 25 || c == 33)) begin bad++; $display("FAIL starve.pulse_cycle got=%0d want=17/25/33", c); end
        total++; if (word_start_o !== 1'b1) begin bad++; $display("FAIL starve.pulse_align c=%0d got=%b want=1", c, word_start_o); end
      end
      if (c == 17) begin
        total++; if (underrun_cnt !== 16'd1) begin bad++; $display("FAIL starve.cnt_c17 got=%h want=0001", underrun_cnt); end
      end
    end
    total++; if (pulses !== 3) begin bad++; $display("FAIL starve.pulses got=%0d want=3", pulses); end
    total++; if (underrun_cnt !== 16'd3) begin bad++; $display("FAIL starve.cnt got=%h want=0003", underrun_cnt); end
    total++; if (ncap !== 6) begin bad++; $display("FAIL starve.nwords got=%0d want=6", ncap); end
    for (int k = 0; k < 6; k++) begin
      total++; if (caps[k] !== expw[k]) begin bad++; $display("FAIL starve.word k=%0d got=%h want=%h", k, caps[k], expw[k]); end
    end
  endtask

  task automatic test_training();
    int         pulses;
    logic [7:0] expw [0:3];
    expw[0] = 8'h00; expw[1] = 8'hF0; expw[2] = 8'hF0; expw[3] = 8'h3C;
    do_reset();
    pulses = 0;
    tx_valid = 1'b1; tx_data = 8'h3C;
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c == 1) begin tx_valid = 1'b0; train = 1'b1; end
      if (c == 17) train = 1'b0;
      if (underrun_o) pulses++;
      if (c >= 2 && c <= 24) begin
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL train.hold_kept c=%0d got=%b want=0", c, tx_ready); end
      end
      if (c == 25) begin
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL train.hold_consumed got=%b want=1", tx_ready); end
      end
    end
    total++; if (ncap !== 4) begin bad++; $display("FAIL train.nwords got=%0d want=4", ncap); end
    for (int k = 0; k < 4; k++) begin
      total++; if (caps[k] !== expw[k]) begin bad++; $display("FAIL train.word k=%0d got=%h want=%h", k, caps[k], expw[k]); end
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL train.pulses got=%0d want=0", pulses); end
    total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL train.cnt got=%h want=0000", underrun_cnt); end
  endtask

  task automatic test_ce_gating();
    logic [23:0] refv;
    int          n;
    int          wi;
    int          acc_off;
    logic        fire;
    logic        ce_now;
    logic        ps, pw, pf;
    refv = {8'h00, 8'hA5, 8'hC3};
    do_reset();
    n = 0; wi = 0; acc_off = 0;
    tx_valid = 1'b1; tx_data = 8'hA5;
    for (int e = 1; e <= 47; e++) begin
      CE     = (e % 2) == 1;
      fire   = tx_valid && tx_ready;
      ce_now = CE;
      ps = serial_o; pw = word_start_o; pf = frame_o;
      tick();
      if (fire) begin
        if (!ce_now) begin
          acc_off++;
          total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL ce.accept_off_ready e=%0d got=%b want=0", e, tx_ready); end
        end
        wi = wi + 1;
        if (wi == 1) tx_data = 8'hC3;
        else tx_valid = 1'b0;
      end
      if (ce_now) begin
        total++; if (serial_o !== refv[23 - n]) begin bad++; $display("FAIL ce.bit n=%0d got=%b want=%b", n, serial_o, refv[23 - n]); end
        n = n + 1;
      end else begin
        total++; if (serial_o !== ps) begin bad++; $display("FAIL ce.hold_serial e=%0d got=%b want=%b", e, serial_o, ps); end
        total++; if (word_start_o !== pw) begin bad++; $display("FAIL ce.hold_ws e=%0d got=%b want=%b", e, word_start_o, pw); end
        total++; if (frame_o !== pf) begin bad++; $display("FAIL ce.hold_frame e=%0d got=%b want=%b", e, frame_o, pf); end
        total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL ce.underrun_off e=%0d got=%b want=0", e, underrun_o); end
      end
    end
    CE = 1'b1;
    total++; if (acc_off < 1) begin bad++; $display("FAIL ce.accept_while_off got=%0d want>=1", acc_off); end
    total++; if (wi !== 2) begin bad++; $display("FAIL ce.accepts got=%0d want=2", wi); end
    total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL ce.cnt got=%h want=0000", underrun_cnt); end
  endtask

  task automatic test_saturation_and_reset();
    logic [15:0] expc;
    int          k;
    do_reset();
    tx_valid = 1'b1; tx_data = 8'h11;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) tx_valid = 1'b0;
    end
    // Jump the counter close to its ceiling instead of running tens of thousands of idle words.
    force dut.underrun_cnt = 16'hFFFD;
    #1;
    release dut.underrun_cnt;
    for (int c = 11; c <= 57; c++) begin
      step();
      if (word_start_o && c >= 17) begin
        k    = (c - 9) / 8;
        expc = (k >= 2) ? 16'hFFFF : 16'hFFFD + 16'(k);
        total++; if (underrun_cnt !== expc) begin bad++; $display("FAIL sat.cnt c=%0d got=%h want=%h", c, underrun_cnt, expc); end
        total++; if (underrun_o !== 1'b1) begin bad++; $display("FAIL sat.pulse c=%0d got=%b want=1", c, underrun_o); end
      end
    end
    // cycle 57 is a word start; fill the holding register, then reset at pos=3.
    tx_valid = 1'b1; tx_data = 8'hEE;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rst.hold_full_before got=%b want=0", tx_ready); end
    RST = 1'b1;
    tick();
    total++; if (serial_o !== 1'b0) begin bad++; $display("FAIL rst.serial got=%b want=0", serial_o); end
    total++; if (frame_o !== 1'b0) begin bad++; $display("FAIL rst.frame got=%b want=0", frame_o); end
    total++; if (word_start_o !== 1'b0) begin bad++; $display("FAIL rst.word_start got=%b want=0", word_start_o); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst.tx_ready got=%b want=1", tx_ready); end
    total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL rst.underrun got=%b want=0", underrun_o); end
    total++; if (underrun_cnt !== 16'h0000) begin bad++; $display("FAIL rst.cnt got=%h want=0000", underrun_cnt); end
    RST = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total++; if (serial_o !== 1'b0) begin bad++; $display("FAIL rst.discard_serial i=%0d got=%b want=0", i, serial_o); end
      total++; if (word_start_o !== (i == 1 || i == 9)) begin bad++; $display("FAIL rst.word_start_after i=%0d got=%b", i, word_start_o); end
      total++; if (underrun_o !== 1'b0) begin bad++; $display("FAIL rst.no_underrun i=%0d got=%b want=0", i, underrun_o); end
    end
  endtask

  initial begin
    RST = 1'b1; CE = 1'b1; tx_valid = 1'b0; train = 1'b0; tx_data = 8'h00;
    ncap = 0; nb = 0; cur = 8'h00;
    test_reset();
    test_first_word();
    test_back_to_back();
    test_starvation();
    test_training();
    test_ce_gating();
    test_saturation_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
